// File: rtl/dif_radix2_64p_tm_ctrl.sv
// -----------------------------------------------------------------------------
// dif_radix2_64p_tm_ctrl
//
// Sequencer for the 64-point DIF twiddle multiplier stage. It tracks the
// sample index inside a 64-sample frame and drives the multiplier's twiddle
// select (tm_ctrl) and update enable (tm_halt_ctrl). It also carries the
// valid/ready handshake, the frame markers and the error flag across the
// multiplier's single register stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready. Once out_valid is raised, it and
// its markers stay stable until out_ready accepts them. in_ready is
// combinational: the output register can take a new sample whenever it is
// empty or is being drained in the same cycle.
//
// Optional feature macro: TM_FRAME_CNT_EN adds frame_cnt and err_cnt.
//
// Ports
//   clk          in   1   clock
//   rst_n        in   1   synchronous reset, active low
//   in_valid     in   1   upstream sample valid
//   in_ready     out  1   upstream may present next sample
//   in_sof       in   1   marks sample 0 of a frame
//   tm_halt_ctrl out  1   multiplier update enable (1 = capture din)
//   tm_ctrl      out  6   multiplier twiddle select, {idx[2:0], idx[5:3]}
//   out_valid    out  1   multiplier output valid
//   out_ready    in   1   downstream accepts
//   out_sof      out  1   output sample is index 0
//   out_eof      out  1   output sample is index 63
//   busy         out  1   a frame is in progress, or output data is pending
//   err_sof      out  1   one-cycle pulse: in_sof arrived in mid-frame
//   dbg_state    out  1   FSM state (0 = IDLE, 1 = RUN)
//   frame_cnt    out  16  (TM_FRAME_CNT_EN) count of issued index-63 samples
//   err_cnt      out  8   (TM_FRAME_CNT_EN) saturating count of err_sof events
// -----------------------------------------------------------------------------
module dif_radix2_64p_tm_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sof,
   output logic        tm_halt_ctrl,
   output logic [5:0]  tm_ctrl,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sof,
   output logic        out_eof,
   output logic        busy,
   output logic        err_sof,
   output logic        dbg_state
`ifdef TM_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [7:0]  err_cnt
`endif
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t     state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic       err_d;
   logic       acc;
   logic       issue;
   logic [5:0] idx;

   // The output register can take a new sample when it is empty or is being
   // drained this cycle. This gives full throughput under continuous ready.
   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;

   // A start-of-frame forces index 0 at any point. Resync happens on that
   // same sample.
   assign idx      = in_sof ? 6'd0 : cnt_q;
   assign tm_ctrl  = {idx[2:0], idx[5:3]};

   // When the FSM is IDLE, samples without in_sof are accepted and thrown
   // away. The multiplier is not updated for them.
   assign issue        = acc && ((state_q == RUN) || in_sof);
   assign tm_halt_ctrl = issue;

   assign busy      = (state_q == RUN) || out_valid;
   assign dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc && in_sof) begin
               state_d = RUN;
               cnt_d   = 6'd1;
            end
         end
         RUN: begin
            if (acc) begin
               if (in_sof) begin
                  // Start-of-frame arrived in mid-frame. Restart at index 1
                  // after this index-0 sample.
                  cnt_d = 6'd1;
                  err_d = (cnt_q != 6'd0);
               end else if (cnt_q == 6'd63) begin
                  state_d = IDLE;
                  cnt_d   = 6'd0;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 6'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         err_sof   <= 1'b0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_sof <= err_d;
         // The sideband register follows the multiplier's single stage.
         // Both registers hold while the downstream stalls.
         if (issue) begin
            out_valid <= 1'b1;
            out_sof   <= (idx == 6'd0);
            out_eof   <= (idx == 6'd63);
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
         end
      end
   end

`ifdef TM_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= 16'd0;
         err_cnt   <= 8'd0;
      end else begin
         // Wraps naturally from 0xFFFF to 0.
         if (issue && (idx == 6'd63))
            frame_cnt <= frame_cnt + 16'd1;
         // Sticky: saturates at 255.
         if (err_d && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dif_radix2_64p_tm_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for dif_radix2_64p_tm_ctrl.
//
// A frame-level reference model decides, for each accepted sample, which
// index it carries. The model also keeps the expected contents of the output
// register. Every issued index goes into exp_q. The queue drains on output
// handshakes, so a lost or duplicated sample shows up as a marker mismatch.
// -----------------------------------------------------------------------------
module tb_dif_radix2_64p_tm_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sof;
   logic        tm_halt_ctrl;
   logic [5:0]  tm_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic        out_sof;
   logic        out_eof;
   logic        busy;
   logic        err_sof;
   logic        dbg_state;
`ifdef TM_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;
`endif

   dif_radix2_64p_tm_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sof       (in_sof),
      .tm_halt_ctrl (tm_halt_ctrl),
      .tm_ctrl      (tm_ctrl),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sof      (out_sof),
      .out_eof      (out_eof),
      .busy         (busy),
      .err_sof      (err_sof),
      .dbg_state    (dbg_state)
`ifdef TM_FRAME_CNT_EN
      ,
      .frame_cnt    (frame_cnt),
      .err_cnt      (err_cnt)
`endif
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard and reference model state
   logic [5:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   bit in_frame;   // a frame is in progress
   int next_idx;   // index the next in-frame sample carries
   bit m_valid, m_sof, m_eof, m_err;
   int m_frames, m_errs;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      in_frame = 0; next_idx = 0;
      m_valid = 0; m_sof = 0; m_eof = 0; m_err = 0;
      m_frames = 0; m_errs = 0;
      exp_q.delete();
   endtask

   // One clock: drive at negedge, check, then advance the model at posedge.
   task automatic step(input bit v, input bit s, input bit r);
      bit rdy, acc, iss, err;
      int idx;
      logic [5:0] e;
      @(negedge clk);
      in_valid = v; in_sof = s; out_ready = r;
      #1;
      rdy = !m_valid || r;
      acc = v && rdy;
      idx = s ? 0 : next_idx;
      iss = acc && (in_frame || s);
      err = acc && s && in_frame;
      check("in_ready", int'(in_ready), int'(rdy));
      check("tm_halt_ctrl", int'(tm_halt_ctrl), int'(iss));
      check("tm_ctrl", int'(tm_ctrl), (idx % 8) * 8 + idx / 8);
      check("out_valid", int'(out_valid), int'(m_valid));
      check("out_sof", int'(out_sof), int'(m_sof));
      check("out_eof", int'(out_eof), int'(m_eof));
      check("busy", int'(busy), int'(in_frame || m_valid));
      check("err_sof", int'(err_sof), int'(m_err));
      check("dbg_state", int'(dbg_state), int'(in_frame));
`ifdef TM_FRAME_CNT_EN
      check("frame_cnt", int'(frame_cnt), m_frames % 65536);
      check("err_cnt", int'(err_cnt), (m_errs > 255) ? 255 : m_errs);
`endif
      if (m_valid && r) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("sb_sof", int'(out_sof), int'(e == 6'd0));
            check("sb_eof", int'(out_eof), int'(e == 6'd63));
         end
      end
      // advance the frame-level model
      m_err = err;
      if (iss) begin
         exp_q.push_back(6'(idx));
         m_valid = 1; m_sof = (idx == 0); m_eof = (idx == 63);
         if (idx == 63) m_frames++;
         if (err) m_errs++;
         if (s) begin
            in_frame = 1; next_idx = 1;
         end else if (idx == 63) begin
            in_frame = 0; next_idx = 0;
         end else begin
            next_idx = idx + 1;
         end
      end else if (r) begin
         m_valid = 0; m_sof = 0; m_eof = 0;
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Sends one full frame, starting with sof, with out_ready held high.
   task automatic frame_full();
      for (int i = 0; i < 64; i++) step(1'b1, i == 0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();

      // reset state
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_tm_ctrl", int'(tm_ctrl), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_halt", int'(tm_halt_ctrl), 0);

      // 1: single full frame, then let it drain
      frame_full();
      repeat (3) step(1'b0, 1'b0, 1'b1);

      // 2: samples without sof while idle are dropped; a following frame starts at 0
      repeat (5) step(1'b1, 1'b0, 1'b1);
      frame_full();
      step(1'b0, 1'b0, 1'b1);

      // 3: downstream stall of 4 cycles at sample 10
      for (int i = 0; i < 11; i++) step(1'b1, i == 0, 1'b1);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      for (int i = 11; i < 64; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);

      // 4: unexpected sof at sample 20; the frame restarts, then completes
      for (int i = 0; i < 20; i++) step(1'b1, i == 0, 1'b1);
      for (int i = 0; i < 64; i++) step(1'b1, i == 0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);

      // 5: reset at sample 30; later samples are dropped until a new sof
      for (int i = 0; i < 30; i++) step(1'b1, i == 0, 1'b1);
      do_reset();
      repeat (5) step(1'b1, 1'b0, 1'b1);
      frame_full();

      // 6: back-to-back frames plus one sof in mid-frame, from a fresh reset
      do_reset();
      frame_full();
      frame_full();
      for (int i = 0; i < 10; i++) step(1'b1, i == 0, 1'b1);
      frame_full();
      step(1'b0, 1'b0, 1'b1);
`ifdef TM_FRAME_CNT_EN
      check("frame_cnt_3", int'(frame_cnt), 3);
      check("err_cnt_1", int'(err_cnt), 1);
`endif

      // randomized traffic with occasional sof and backpressure
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 79) == 0),
              1'($urandom_range(0, 3) != 0));
      // drain
      repeat (70) step(1'b1, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      check("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
